rtc_smartwatch: RTL and testbench
=================================

RTC_SMARTWATCH -- requirements
Module: rtc_smartwatch

Interface
REQ-001 SHALL have parameter: CLOCK_RATE, 50000000, clk frequency in Hz; used only when SMARTWATCH_HUNDREDTHS_EN is defined.
REQ-002 SHALL have port: clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port: RESET_N  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports: I_YEAR in 7, I_MNTH in 4, I_DMTH in 5, I_DWK in 3, I_HOUR in 5, I_MIN in 6, I_SEC in 6; binary time fields from the RTC timekeeper.
- I_DWK: range 1..7.
- I_HOUR: 24-hour format.
REQ-005 SHALL have port: CS  in  1  level; CPU access in progress inside the SmartWatch ROM window.
REQ-006 SHALL have port: ADDR  in  3  CPU address bits A2..A0 of the current access.
REQ-007 SHALL have port: ACC_STB  in  1  single-cycle pulse marking completion of one CPU access; asserted only while CS=1.
REQ-008 SHALL have port: DOUT  out  1  clock data bit for CPU data bus D0.
REQ-009 SHALL have port: DOUT_EN  out  1  when 1, the bus mux SHALL replace ROM D0 with DOUT.

Function
REQ-010 SHALL implement two states.
- MATCH: watching for the recognition pattern.
- DATA: streaming time bits.
REQ-011 An access with ADDR[2]=0 SHALL be a write access; its data bit is ADDR[0]. An access with ADDR[2]=1 SHALL be a read access.
REQ-012 Recognition pattern SHALL be bytes C5 3A A3 5C C5 3A A3 5C, 64 bits, each byte LSB first; a 6-bit index tracks progress.
REQ-013 In MATCH, on ACC_STB with a write access:
- if ADDR[0] equals pattern bit[index], index increments;
- otherwise index SHALL clear to 0, and the mismatching bit is not re-evaluated as bit 0.
REQ-014 In MATCH, on ACC_STB with a read access, index SHALL clear to 0.
REQ-015 On the strobe that matches bit 63:
- a 64-bit snapshot SHALL be loaded from the current inputs;
- state SHALL go to DATA with bit counter 0.
REQ-016 Snapshot byte order, byte0 first, all fields BCD:
- byte0: hundredths;
- byte1: seconds, bit7=0;
- byte2: minutes;
- byte3: hours, bit7=0 (24h mode);
- byte4: day, bits 7:3=0;
- byte5: date;
- byte6: month;
- byte7: year.
REQ-017 Binary-to-BCD conversion SHALL be exact for 0..99; any input above 99 SHALL yield 99.
REQ-018 In DATA, DOUT SHALL equal snapshot[bit counter]. DOUT_EN SHALL be 1 exactly when state=DATA and CS=1 and ADDR[2]=1, combinationally.
REQ-019 In DATA, every ACC_STB (read or write) SHALL advance the bit counter. Write-access data SHALL be discarded; the clock is not settable.
REQ-020 The strobe at bit counter 63 SHALL return the block to MATCH with index 0.
REQ-021 The snapshot SHALL NOT change during DATA, even if the input fields roll over.
REQ-022 Outside DATA, DOUT_EN SHALL be 0 and DOUT SHALL be 0.
REQ-023 ACC_STB with CS=0 SHALL be ignored.

Reset
REQ-024 RESET_N=0 SHALL immediately clear all of the following:
- state to MATCH;
- index, bit counter and snapshot to 0;
- hundredths counter to 0;
- DOUT=0 and DOUT_EN=0.
REQ-025 A reset during DATA SHALL abort the stream; the next access SHALL be treated as pattern bit 0.

Configuration
REQ-026 With SMARTWATCH_HUNDREDTHS_EN defined, the block SHALL count hundredths:
- a prescaler SHALL advance a BCD counter 00..99 every CLOCK_RATE/100 clocks, wrapping 99->00;
- the counter and prescaler SHALL clear whenever I_SEC changes;
- snapshot byte0 SHALL take this counter value.
REQ-027 Without SMARTWATCH_HUNDREDTHS_EN, no prescaler or counter logic SHALL exist and snapshot byte0 SHALL be 00.

Verification
REQ-028 Inputs 2023-07-15 13:45:30, I_DWK=6; 64 pattern writes, then 64 reads -> bytes 00 30 45 13 06 15 07 23, each LSB first, DOUT_EN=1 on every read.
REQ-029 Correct first 40 pattern bits, then one wrong bit, then the full pattern -> DATA entered only after the final 64-bit run, and DOUT_EN=0 before it.
REQ-030 Read access after 20 good bits, then 64 good bits -> match on the last of those 64 bits.
REQ-031 Inputs change from 23:59:59 to 00:00:00 during the DATA stream -> streamed bytes still read 59 59 23.
REQ-032 RESET_N pulsed low after 10 data bits -> DOUT_EN=0 at once; the next 64 reads return DOUT_EN=0; a full pattern then rematches.
REQ-033 With SMARTWATCH_HUNDREDTHS_EN and CLOCK_RATE=10000: 50 ms after an I_SEC change, match and read -> byte0=0x05.

Source files
------------

// File: rtl/rtc_smartwatch.sv
// SmartWatch-style RTC: detects a 64-bit unlock sequence written through ROM address lines,
// then serially streams a BCD time snapshot on D0. Optional macro: SMARTWATCH_HUNDREDTHS_EN.
module rtc_smartwatch #(
    parameter int CLOCK_RATE = 50000000
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic [6:0] I_YEAR,
    input  logic [3:0] I_MNTH,
    input  logic [4:0] I_DMTH,
    input  logic [2:0] I_DWK,
    input  logic [4:0] I_HOUR,
    input  logic [5:0] I_MIN,
    input  logic [5:0] I_SEC,
    input  logic       CS,
    input  logic [2:0] ADDR,
    input  logic       ACC_STB,
    output logic       DOUT,
    output logic       DOUT_EN
);

    typedef enum logic {
        ST_MATCH = 1'b0,
        ST_DATA  = 1'b1
    } state_e;

    // Bytes C5 3A A3 5C C5 3A A3 5C, byte0 in the low byte, consumed LSB first.
    localparam logic [63:0] PATTERN = 64'h5CA3_3AC5_5CA3_3AC5;

    state_e      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  bit_q, bit_d;
    logic [63:0] snap_q, snap_d;
    logic [63:0] snap_now;
    logic [7:0]  hund_bcd;
    logic        strobe;
    logic        is_read;
    logic        unused_ok;

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [7:0] w;
        w = {1'b0, v};
        if (w > 8'd99) begin
            return 8'h99;
        end
        return ((w / 8'd10) * 8'd16) + (w % 8'd10);
    endfunction

    assign strobe  = ACC_STB & CS;
    assign is_read = ADDR[2];

    // Only A2 (read/write) and A0 (data bit) carry meaning.
    assign unused_ok = ADDR[1] ^ (CLOCK_RATE > 0);

`ifdef SMARTWATCH_HUNDREDTHS_EN
    localparam int PRESCALE = (CLOCK_RATE / 100 > 1) ? CLOCK_RATE / 100 : 1;
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q;
    logic [5:0]    sec_q;
    logic [7:0]    hund_q;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = v[7:4];
        lo = v[3:0];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    // The hundredths counter restarts on every seconds edge so it stays aligned to I_SEC.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            presc_q <= '0;
            sec_q   <= '0;
            hund_q  <= '0;
        end else begin
            sec_q <= I_SEC;
            if (I_SEC != sec_q) begin
                presc_q <= '0;
                hund_q  <= '0;
            end else if (presc_q == PW'(PRESCALE - 1)) begin
                presc_q <= '0;
                hund_q  <= bcd_inc(hund_q);
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    assign hund_bcd = hund_q;
`else
    assign hund_bcd = 8'h00;
`endif

    assign snap_now = {
        to_bcd(I_YEAR),
        to_bcd({3'b000, I_MNTH}),
        to_bcd({2'b00, I_DMTH}),
        {5'b00000, I_DWK},
        to_bcd({2'b00, I_HOUR}),
        to_bcd({1'b0, I_MIN}),
        to_bcd({1'b0, I_SEC}),
        hund_bcd
    };

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        snap_d  = snap_q;
        case (state_q)
            ST_MATCH: begin
                if (strobe) begin
                    if (is_read) begin
                        idx_d = '0;
                    end else if (ADDR[0] == PATTERN[idx_q]) begin
                        if (idx_q == 6'd63) begin
                            state_d = ST_DATA;
                            idx_d   = '0;
                            bit_d   = '0;
                            snap_d  = snap_now;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end else begin
                        // A mismatching bit is dropped, not retried as the first pattern bit.
                        idx_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (strobe) begin
                    if (bit_q == 6'd63) begin
                        state_d = ST_MATCH;
                        idx_d   = '0;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 6'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_MATCH;
            idx_q   <= '0;
            bit_q   <= '0;
            // NOTE: the snapshot is a plain register, not a RAM, so clearing it on reset is cheap.
            snap_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            snap_q  <= snap_d;
        end
    end

    assign DOUT    = (state_q == ST_DATA) ? snap_q[bit_q] : 1'b0;
    assign DOUT_EN = (state_q == ST_DATA) && CS && ADDR[2];

endmodule

// File: tb/tb_rtc_smartwatch.sv
// Self-checking bench for rtc_smartwatch: directed scenarios plus randomized time fields,
// checked against an arithmetic BCD model. Honours SMARTWATCH_HUNDREDTHS_EN if defined.
module tb_rtc_smartwatch;

`ifdef SMARTWATCH_HUNDREDTHS_EN
    localparam int CR = 10000;
`else
    localparam int CR = 50000000;
`endif

    logic       clk = 1'b0;
    logic       RESET_N;
    logic [6:0] I_YEAR;
    logic [3:0] I_MNTH;
    logic [4:0] I_DMTH;
    logic [2:0] I_DWK;
    logic [4:0] I_HOUR;
    logic [5:0] I_MIN;
    logic [5:0] I_SEC;
    logic       CS;
    logic [2:0] ADDR;
    logic       ACC_STB;
    logic       DOUT;
    logic       DOUT_EN;

    int checks = 0;
    int errors = 0;
    byte unsigned pat[8] = '{8'hC5, 8'h3A, 8'hA3, 8'h5C, 8'hC5, 8'h3A, 8'hA3, 8'h5C};
    logic [7:0] exp_bytes[8];

    rtc_smartwatch #(.CLOCK_RATE(CR)) dut (
        .clk(clk), .RESET_N(RESET_N),
        .I_YEAR(I_YEAR), .I_MNTH(I_MNTH), .I_DMTH(I_DMTH), .I_DWK(I_DWK),
        .I_HOUR(I_HOUR), .I_MIN(I_MIN), .I_SEC(I_SEC),
        .CS(CS), .ADDR(ADDR), .ACC_STB(ACC_STB),
        .DOUT(DOUT), .DOUT_EN(DOUT_EN)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        if (v > 99) return 8'h99;
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic logic pbit(input int i);
        logic [7:0] t;
        t = pat[i / 8];
        return t[i % 8];
    endfunction

    task automatic set_time(input int y, input int mo, input int d, input int w,
                            input int h, input int mi, input int s);
        I_YEAR = 7'(y); I_MNTH = 4'(mo); I_DMTH = 5'(d); I_DWK = 3'(w);
        I_HOUR = 5'(h); I_MIN = 6'(mi); I_SEC = 6'(s);
    endtask

    task automatic compute_exp();
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = bcd(int'(I_SEC));
        exp_bytes[2] = bcd(int'(I_MIN));
        exp_bytes[3] = bcd(int'(I_HOUR));
        exp_bytes[4] = {5'b00000, I_DWK};
        exp_bytes[5] = bcd(int'(I_DMTH));
        exp_bytes[6] = bcd(int'(I_MNTH));
        exp_bytes[7] = bcd(int'(I_YEAR));
    endtask

    // One CPU access: outputs sampled mid-access, strobe registered on the following edge.
    task automatic access(input logic rd, input logic b, output logic dout, output logic den);
        @(negedge clk);
        CS = 1'b1; ADDR = {rd, 1'b0, b}; ACC_STB = 1'b1;
        #1;
        dout = DOUT; den = DOUT_EN;
        @(negedge clk);
        ACC_STB = 1'b0; CS = 1'b0; ADDR = 3'b000;
    endtask

    task automatic peek(output logic dout, output logic den);
        @(negedge clk);
        CS = 1'b1; ADDR = 3'b100; ACC_STB = 1'b0;
        #1;
        dout = DOUT; den = DOUT_EN;
        CS = 1'b0; ADDR = 3'b000;
    endtask

    task automatic send_range(input int lo, input int hi);
        logic d, e;
        for (int i = lo; i <= hi; i++) access(1'b0, pbit(i), d, e);
    endtask

    task automatic do_match();
        logic d, e;
        access(1'b1, 1'b0, d, e);
        compute_exp();
        send_range(0, 63);
    endtask

    task automatic read_bits(input string tag, input int lo, input int hi, input bit full_b0);
        logic [63:0] obs, msk, expv;
        int den_bad;
        logic d, e;
        obs = '0; msk = '0; den_bad = 0;
        for (int i = lo; i <= hi; i++) begin
            access(1'b1, 1'b0, d, e);
            obs[i] = d;
            msk[i] = 1'b1;
            if (e !== 1'b1) den_bad++;
        end
        for (int k = 0; k < 8; k++) expv[k*8 +: 8] = exp_bytes[k];
`ifdef SMARTWATCH_HUNDREDTHS_EN
        if (!full_b0) msk[7:0] = 8'h00;
`else
        if (full_b0) msk[7:0] = msk[7:0];
`endif
        check({tag, "_data"}, obs & msk, expv & msk);
        check({tag, "_den"}, 64'(den_bad), 64'd0);
    endtask

    initial begin
        logic d, e;
        int ones;
        RESET_N = 1'b0; CS = 1'b0; ADDR = 3'b000; ACC_STB = 1'b0;
        set_time(0, 1, 1, 1, 0, 0, 0);

        peek(d, e);
        check("reset_dout", 64'(d), 64'd0);
        check("reset_den", 64'(e), 64'd0);
        repeat (2) @(negedge clk);
        RESET_N = 1'b1;
        peek(d, e);
        check("idle_dout", 64'(d), 64'd0);
        check("idle_den", 64'(e), 64'd0);

        // Reference vector 2023-07-15 13:45:30, Saturday.
        set_time(23, 7, 15, 6, 13, 45, 30);
        exp_bytes = '{8'h00, 8'h30, 8'h45, 8'h13, 8'h06, 8'h15, 8'h07, 8'h23};
        send_range(0, 62);
        peek(d, e);
        check("ref_den_at63", 64'(e), 64'd0);
        send_range(63, 63);
        peek(d, e);
        check("ref_den_matched", 64'(e), 64'd1);
        read_bits("ref", 0, 63, 1'b0);
        peek(d, e);
        check("ref_back_match_den", 64'(e), 64'd0);
        check("ref_back_match_dout", 64'(d), 64'd0);

        // Writes in DATA advance the stream but are never driven back.
        set_time(99, 12, 31, 7, 23, 59, 58);
        do_match();
        access(1'b0, 1'b1, d, e);
        check("data_write_den", 64'(e), 64'd0);
        read_bits("data_write", 1, 63, 1'b0);

        // 40 good bits, one wrong, then the full pattern.
        set_time(5, 3, 9, 2, 7, 8, 9);
        access(1'b1, 1'b0, d, e);
        compute_exp();
        send_range(0, 39);
        access(1'b0, ~pbit(40), d, e);
        peek(d, e);
        check("wrong_bit_den", 64'(e), 64'd0);
        send_range(0, 62);
        peek(d, e);
        check("wrong_bit_den_at63", 64'(e), 64'd0);
        send_range(63, 63);
        peek(d, e);
        check("wrong_bit_matched", 64'(e), 64'd1);
        read_bits("wrong_bit", 0, 63, 1'b0);

        // Read access after 20 good bits restarts the recognizer.
        set_time(42, 6, 20, 3, 18, 30, 12);
        access(1'b1, 1'b0, d, e);
        compute_exp();
        send_range(0, 19);
        access(1'b1, 1'b0, d, e);
        send_range(0, 62);
        peek(d, e);
        check("read_clr_den_at63", 64'(e), 64'd0);
        send_range(63, 63);
        peek(d, e);
        check("read_clr_matched", 64'(e), 64'd1);
        read_bits("read_clr", 0, 63, 1'b0);

        // Snapshot holds while inputs roll over mid-stream.
        set_time(24, 12, 31, 7, 23, 59, 59);
        do_match();
        read_bits("rollover_a", 0, 23, 1'b0);
        set_time(25, 1, 1, 1, 0, 0, 0);
        read_bits("rollover_b", 24, 63, 1'b0);

        // Asynchronous reset mid-stream.
        set_time(11, 11, 11, 4, 11, 11, 11);
        do_match();
        read_bits("pre_reset", 0, 9, 1'b0);
        @(negedge clk);
        CS = 1'b1; ADDR = 3'b100;
        #1 RESET_N = 1'b0;
        #1;
        check("async_reset_den", 64'(DOUT_EN), 64'd0);
        check("async_reset_dout", 64'(DOUT), 64'd0);
        #1 RESET_N = 1'b1;
        CS = 1'b0; ADDR = 3'b000;
        ones = 0;
        for (int i = 0; i < 64; i++) begin
            access(1'b1, 1'b0, d, e);
            if (e === 1'b1) ones++;
        end
        check("post_reset_reads_den", 64'(ones), 64'd0);
        do_match();
        read_bits("rematch", 0, 63, 1'b0);

        // Strobes with CS low are ignored in both states.
        set_time(88, 9, 17, 5, 21, 3, 47);
        access(1'b1, 1'b0, d, e);
        compute_exp();
        for (int i = 0; i < 64; i++) begin
            access(1'b0, pbit(i), d, e);
            @(negedge clk);
            ADDR = {2'b00, ~pbit(i + 1 < 64 ? i + 1 : 0)}; ACC_STB = 1'b1;
            @(negedge clk);
            ACC_STB = 1'b0; ADDR = 3'b000;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ADDR = 3'b100; ACC_STB = 1'b1;
            @(negedge clk);
            ACC_STB = 1'b0; ADDR = 3'b000;
        end
        read_bits("cs_low", 0, 63, 1'b0);

        // Randomized fields, including out-of-range values that saturate to 99.
        for (int n = 0; n < 8; n++) begin
            set_time($urandom_range(127), $urandom_range(15), $urandom_range(31),
                     $urandom_range(7, 1), $urandom_range(31), $urandom_range(63),
                     $urandom_range(63));
            do_match();
            read_bits("random", 0, 63, 1'b0);
        end

`ifdef SMARTWATCH_HUNDREDTHS_EN
        // 50 ms after a seconds edge at 10 kHz the hundredths byte reads 05.
        set_time(23, 7, 15, 6, 13, 45, 30);
        @(negedge clk);
        I_SEC = 6'd31;
        repeat (420) @(negedge clk);
        do_match();
        exp_bytes[0] = 8'h05;
        read_bits("hundredths", 0, 63, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
